// File: rtl/monitor_verdict_fifo.sv
`default_nettype none
// ============================================================================
// Module   : monitor_verdict_fifo
// Purpose  : Captures monitor stream values on each eval pulse into a small
//            FIFO, drains them over valid/ready, counts dropped entries.
// Revision : 1.0 - initial release
// ============================================================================
module monitor_verdict_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_s0,
    input  logic [DATA_W-1:0]     in_s1,
    input  logic [DATA_W-1:0]     in_s2,
    input  logic [DATA_W-1:0]     in_s3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [ADDR_W:0]       level,
    output logic                  overflow,
    output logic [CNT_W-1:0]      drop_count
);

    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

    logic [4*DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    drop_count_q, drop_count_d;

    logic w_push, w_pop, w_full, w_accept, w_drop;

    assign w_push   = en & in_valid;
    assign w_pop    = (level_q != '0) & out_ready;
    assign w_full   = (level_q == LVL_FULL);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_accept, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= {in_s3, in_s2, in_s1, in_s0};
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire
